// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// spi_reg_ctrl : SPI frame parser driving an 8-bit register bank (rev 1.0)
// Optional burst (address auto-increment) mode: define SPI_AUTOINC_EN.
// ============================================================================
module spi_reg_ctrl #(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic [7:0]         rx_data,
    input  logic               data_valid,
    output logic [7:0]         tx_data,
    output logic               tx_load,
    output logic [NREGS*8-1:0] reg_q,
    output logic               wr_pulse,
    output logic [AW-1:0]      wr_addr,
    output logic               err_addr,
    output logic [7:0]         frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_SKIP = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
    localparam logic [7:0]    NREGS_B   = 8'(NREGS);

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      regs_q [NREGS];
    logic [7:0]      regs_d [NREGS];
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_load_q, tx_load_d;
    logic            wr_pulse_q, wr_pulse_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            err_addr_q, err_addr_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    logic            cs_meta_q, cs_s_q, cs_prev_q;
    logic            w_cs_rise;
    logic [AW-1:0]   w_addr_inc;

    // Synchronizer idles high so reset looks like "deselected".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= cs;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
        end
    end

    assign w_cs_rise  = cs_s_q & ~cs_prev_q;
    assign w_addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_addr_d  = err_addr_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!cs_s_q) state_d = S_CMD;
            end
            S_CMD: begin
                if (data_valid) begin
                    if ({1'b0, rx_data[6:0]} >= NREGS_B) begin
                        err_addr_d = 1'b1;
                        state_d    = S_SKIP;
                    end else begin
                        addr_d = rx_data[AW-1:0];
                        if (rx_data[7]) begin
                            tx_data_d = regs_q[rx_data[AW-1:0]];
                            tx_load_d = 1'b1;
                            state_d   = S_RD;
                        end else begin
                            state_d = S_WR;
                        end
                    end
                end
            end
            S_WR: begin
                if (data_valid) begin
                    regs_d[addr_q] = rx_data;
                    wr_pulse_d     = 1'b1;
                    wr_addr_d      = addr_q;
`ifdef SPI_AUTOINC_EN
                    addr_d = w_addr_inc;
`else
                    state_d = S_SKIP;
`endif
                end
            end
            S_RD: begin
                // The received byte is a dummy; only its arrival matters.
                if (data_valid) begin
`ifdef SPI_AUTOINC_EN
                    addr_d    = w_addr_inc;
                    tx_data_d = regs_q[w_addr_inc];
                    tx_load_d = 1'b1;
`else
                    state_d = S_SKIP;
`endif
                end
            end
            S_SKIP: begin
                state_d = S_SKIP;
            end
            default: state_d = S_IDLE;
        endcase

        // Frame end wins over the state choice, after the byte was handled.
        if (w_cs_rise) begin
            state_d     = S_IDLE;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            regs_q      <= '{default: '0};
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            err_addr_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            err_addr_q  <= err_addr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        assign reg_q[8*i +: 8] = regs_q[i];
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign err_addr  = err_addr_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_ctrl : randomized frames against a frame-level reference model
// ============================================================================
module tb_spi_reg_ctrl;

    localparam int NREGS = 8;
    localparam int AW    = 3;
`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        bit         is_rd;
        int         addr;
        logic [7:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cs;
    logic [7:0]         rx_data;
    logic               data_valid;
    logic [7:0]         tx_data;
    logic               tx_load;
    logic [NREGS*8-1:0] reg_q;
    logic               wr_pulse;
    logic [AW-1:0]      wr_addr;
    logic               err_addr;
    logic [7:0]         frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    exp_t       sb[$];
    logic [7:0] m_regs [NREGS];
    logic       m_err;
    logic [7:0] m_frame;

    spi_reg_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rx_data(rx_data),
        .data_valid(data_valid), .tx_data(tx_data), .tx_load(tx_load),
        .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .err_addr(err_addr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_err   = 1'b0;
        m_frame = 8'h00;
        sb.delete();
    endfunction

    // Frame semantics: command byte then data bytes, evaluated as a whole.
    function automatic void model_frame(byte_q_t b);
        exp_t e;
        int   a;
        m_frame = m_frame + 8'd1;
        if (b.size() == 0) return;
        a = int'(b[0][6:0]);
        if (a >= NREGS) begin
            m_err = 1'b1;
            return;
        end
        if (!b[0][7]) begin
            for (int k = 1; k < b.size(); k++) begin
                if (!AUTOINC && k > 1) break;
                e.is_rd = 1'b0;
                e.addr  = (a + k - 1) % NREGS;
                e.data  = b[k];
                m_regs[e.addr] = b[k];
                sb.push_back(e);
            end
        end else begin
            e.is_rd = 1'b1;
            e.addr  = a;
            e.data  = m_regs[a];
            sb.push_back(e);
            for (int k = 1; k < b.size(); k++) begin
                if (!AUTOINC) break;
                e.addr = (a + k) % NREGS;
                e.data = m_regs[e.addr];
                sb.push_back(e);
            end
        end
    endfunction

    // Monitor: every strobe from the DUT consumes one expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wr_pulse === 1'b1 || tx_load === 1'b1)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: wr_pulse=%0b tx_load=%0b, none expected",
                         wr_pulse, tx_load);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {62'd0, wr_pulse, tx_load}, e.is_rd ? 64'd1 : 64'd2);
                if (e.is_rd) begin
                    check("tx_data", 64'(tx_data), 64'(e.data));
                end else begin
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_reg_value", 64'(reg_q[8*e.addr +: 8]), 64'(e.data));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data    = b;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        rx_data    = 8'($urandom);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_reg_q"}, reg_q, model_flat());
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frame));
        check({tag, "_err_addr"}, 64'(err_addr), 64'(m_err));
    endtask

    task automatic run_frame(input byte_q_t b, input bit last_at_rise, input bit rand_gaps);
        int n;
        model_frame(b);
        n = b.size();
        cs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            if (last_at_rise && k == n - 1) begin
                cs = 1'b0;
            end else begin
                send_byte(b[k]);
                if (rand_gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
                if (rand_gaps) #1;
            end
        end
        cs = 1'b1;
        if (last_at_rise && n > 0) begin
            // Byte arrives in the same cycle the synchronized frame end is seen.
            repeat (2) @(posedge clk);
            #1;
            send_byte(b[n-1]);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_q"}, reg_q, 64'd0);
        check({tag, "_misc"}, {38'd0, tx_data, tx_load, wr_pulse, wr_addr, err_addr, frame_cnt},
              64'd0);
    endtask

    initial begin
        byte_q_t q;
        rst_n      = 1'b0;
        cs         = 1'b1;
        rx_data    = 8'h00;
        data_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        end_checks("post_reset");

        q = '{8'h03, 8'hA5};
        run_frame(q, 1'b0, 1'b0);
        end_checks("write");
        check("write_reg3", 64'(reg_q[31:24]), 64'hA5);

        q = '{8'h83};
        run_frame(q, 1'b0, 1'b0);
        end_checks("read");

        q = '{8'h7F, 8'h55};
        run_frame(q, 1'b0, 1'b0);
        end_checks("bad_addr");
        check("bad_addr_err", 64'(err_addr), 64'd1);

        q = '{8'h06, 8'h11, 8'h22, 8'h33};
        run_frame(q, 1'b0, 1'b1);
        end_checks("burst");
        check("burst_reg6", 64'(reg_q[55:48]), 64'h11);
        check("burst_reg7", 64'(reg_q[63:56]), AUTOINC ? 64'h22 : 64'h00);
        check("burst_reg0", 64'(reg_q[7:0]), AUTOINC ? 64'h33 : 64'h00);

        q = '{8'h02};
        run_frame(q, 1'b0, 1'b0);
        end_checks("abort");

        q = '{8'h04, 8'h5A};
        run_frame(q, 1'b1, 1'b0);
        end_checks("byte_at_frame_end");

        send_byte(8'hC3);
        repeat (3) @(posedge clk);
        #1;
        end_checks("idle_stray_byte");

        // Reset while a write frame is in progress.
        cs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h05);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("mid_frame_reset");
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        q = '{8'h01, 8'h7E};
        run_frame(q, 1'b0, 1'b0);
        end_checks("after_reset");
        check("after_reset_reg1", 64'(reg_q[15:8]), 64'h7E);

        for (int f = 0; f < 40; f++) begin
            int nd;
            logic [7:0] cmd;
            cmd[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(NREGS, 127))
                                                   : 7'($urandom_range(0, NREGS - 1));
            cmd[7]   = 1'($urandom_range(0, 1));
            q = '{cmd};
            nd = $urandom_range(0, 4);
            for (int k = 0; k < nd; k++) q.push_back(8'($urandom));
            run_frame(q, (nd > 0) && ($urandom_range(0, 4) == 0), 1'b1);
            end_checks("random");
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
